// File: rtl/cla_seq64.sv
// Sequential W-bit adder/subtractor built from one 16-bit carry-lookahead
// adder (cla16). The adder is reused once per 16-bit chunk, LSB chunk first.
// The carry is carried between chunks in a register.

// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [3:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate and propagate for each 4-bit group.
    always_comb begin
        gg = '0;
        pg = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
    end

    // Lookahead carries into each group, flattened from cin.
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        gc[1] = gg[0] | (pg[0] & cin);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
    end

    // Bit carries inside each group from the group carry-in.
    always_comb begin
        c = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign sum = p ^ c;
endmodule

// Top level: request/response handshake around the time-multiplexed cla16.
module cla_seq64 #(
    parameter int NCHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [16*NCHUNK-1:0] req_a,
    input  logic [16*NCHUNK-1:0] req_b,
    input  logic                 req_sub,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [16*NCHUNK-1:0] resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf
);
    localparam int W  = 16 * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   res_q;
    logic [W-1:0]   res_next;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [15:0]    ca;
    logic [15:0]    cb;
    logic [15:0]    cs;
    logic           chunk_cout;
    logic           last;
    logic           accept;

    assign ca         = a_q[idx*16 +: 16];
    assign cb         = b_q[idx*16 +: 16];
    assign chunk_cout = (ca[15] & cb[15]) | ((ca[15] | cb[15]) & ~cs[15]);
    assign last       = (idx == LAST_IDX);
    assign accept     = req_valid & req_ready;

    cla16 u_cla16 (
        .a   (ca),
        .b   (cb),
        .cin (carry),
        .sum (cs)
    );

    // Working result with the current chunk merged in.
    always_comb begin
        res_next = res_q;
        res_next[idx*16 +: 16] = cs;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, per-chunk accumulation; visible outputs load only on the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            resp_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= req_a;
                        b_q   <= req_sub ? ~req_b : req_b;
                        carry <= req_sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    res_q <= res_next;
                    carry <= chunk_cout;
                    if (last) begin
                        resp_sum  <= res_next;
                        resp_cout <= chunk_cout;
                        resp_ovf  <= (a_q[W-1] == b_q[W-1]) & (cs[15] != a_q[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq64.sv
// Self-checking bench for cla_seq64: directed vector table, handshake corner
// sequences, and random operations against an arithmetic reference model.
module tb_cla_seq64;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_sub;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_sum;
    logic        resp_cout;
    logic        resp_ovf;

    int total = 0;
    int bad   = 0;

    cla_seq64 #(.NCHUNK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: full-width arithmetic with 65-bit result and signed overflow rules.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         output logic [63:0] s, output logic c, output logic o);
        logic [64:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
        else     r = {1'b0, a} + {1'b0, b};
        s = r[63:0];
        c = r[64];
        if (sub) o = (a[63] != b[63]) && (s[63] != a[63]);
        else     o = (a[63] == b[63]) && (s[63] != a[63]);
    endtask

    // One operation: accept, wait for result (latency checked), optional hold, consume.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input int hold, input bit scramble,
                          output logic [63:0] s, output logic c, output logic o);
        logic [63:0] prev_sum;
        int cycles;
        bit held_ok;
        @(negedge clk);
        check("ready_idle", {63'd0, req_ready}, 64'd1);
        prev_sum  = resp_sum;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cycles    = 0;
        held_ok   = 1'b1;
        while (!resp_valid && cycles <= 20) begin
            if (scramble) begin
                req_a   = {$urandom, $urandom};
                req_b   = {$urandom, $urandom};
                req_sub = 1'($urandom);
                req_valid = 1'b1;
            end
            if (resp_sum !== prev_sum || req_ready !== 1'b0) held_ok = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        req_valid = 1'b0;
        check("hold_in_run", {63'd0, held_ok}, 64'd1);
        check("latency", 64'(cycles), 64'd4);
        s = resp_sum;
        c = resp_cout;
        o = resp_ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_ready", {63'd0, req_ready}, 64'd0);
            check("bp_sum", resp_sum, s);
            check("bp_flags", {62'd0, resp_cout, resp_ovf}, {62'd0, c, o});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("consume_valid", {63'd0, resp_valid}, 64'd0);
        check("consume_ready", {63'd0, req_ready}, 64'd1);
    endtask

    vec_t        vt[6];
    logic [63:0] gs, es;
    logic        gc, go, ec, eo;
    logic [63:0] ra, rb;
    logic        rs;
    bit          saw_valid;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_sum", resp_sum, 64'd0);
        check("rst_flags", {62'd0, resp_cout, resp_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vt[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vt[5] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].sub, 0, 1'b0, gs, gc, go);
            check("vec_sum", gs, vt[i].s);
            check("vec_cout", {63'd0, gc}, {63'd0, vt[i].c});
            check("vec_ovf", {63'd0, go}, {63'd0, vt[i].o});
        end

        // Backpressure: hold the result for 10 cycles.
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 10, 1'b0, gs, gc, go);
        check("bp_result", gs, 64'h2222_2222_2222_2211);

        // Operand isolation: inputs scrambled every RUN cycle.
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 0, 1'b1, gs, gc, go);
        model(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, es, ec, eo);
        check("iso_sum", gs, es);
        check("iso_flags", {62'd0, gc, go}, {62'd0, ec, eo});

        // Reset during chunk 2 aborts the operation.
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b     = 64'h1;
        req_sub   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_sum", resp_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid) saw_valid = 1'b1;
        end
        check("no_stale_valid", {63'd0, saw_valid}, 64'd0);
        run_op(64'd3, 64'd4, 1'b0, 0, 1'b0, gs, gc, go);
        check("post_rst_sum", gs, 64'd7);
        check("post_rst_flags", {62'd0, gc, go}, 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ((i % 5) == 0) ra = ra | 64'hFFFF_FFFF_FFFF_0000;
            if ((i % 7) == 0) rb = 64'(i);
            rs = 1'($urandom);
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'($urandom), gs, gc, go);
            model(ra, rb, rs, es, ec, eo);
            check("rand_sum", gs, es);
            check("rand_cout", {63'd0, gc}, {63'd0, ec});
            check("rand_ovf", {63'd0, go}, {63'd0, eo});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cla_seq64.md
CLA_SEQ64 -- requirements
Module: cla_seq64

Interface
REQ-001 SHALL have parameter NCHUNK, default 4, the number of 16-bit chunks per operand; operand width W = 16*NCHUNK.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  1  request operands valid.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_a  input  W  first operand.
REQ-007 SHALL have port req_b  input  W  second operand.
REQ-008 SHALL have port req_sub  input  1  1 = compute a-b, 0 = compute a+b.
REQ-009 SHALL have port resp_valid  output  1  result valid.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_sum  output  W  result, modulo 2^W.
REQ-012 SHALL have port resp_cout  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
REQ-013 SHALL have port resp_ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL compute each chunk with exactly one instance of the team's 16-bit carry-lookahead adder, cla16, time-multiplexed across chunks, least-significant chunk first.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL, on accept, latch req_a, latch req_b (bitwise inverted when req_sub=1), set the carry register to req_sub, clear the chunk index, and move to RUN.
REQ-018 SHALL, in each RUN cycle k, present chunk k of the latched operands and the carry register to cla16, and write the 16-bit sum into chunk k of the result register.
REQ-019 SHALL, in each RUN cycle k, update the carry register to the chunk carry-out, computed as (a15&b15) | ((a15|b15) & ~s15) on that chunk's bit 15.
REQ-020 SHALL increment the chunk index each RUN cycle; it moves to DONE on the edge that completes chunk NCHUNK-1, with no wrap-around into chunk 0.
REQ-021 SHALL assert resp_valid exactly NCHUNK cycles after the accepting edge (NCHUNK=4: accept at edge T, resp_valid high after edge T+4).
REQ-022 SHALL assert resp_valid only in DONE.
REQ-023 SHALL hold resp_valid, resp_sum, resp_cout and resp_ovf stable in DONE until resp_ready=1 is sampled, then return to IDLE.
REQ-024 SHALL drive resp_cout equal to the final carry register.
REQ-025 SHALL drive resp_ovf = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), where b' is the latched, possibly inverted, operand.
REQ-026 SHALL ignore req_valid, req_a, req_b and req_sub in RUN and DONE; operands change after accept SHALL NOT affect the result.
REQ-027 SHALL NOT accept a new request in the same cycle a result is consumed; at least one IDLE cycle separates consecutive operations.
REQ-028 SHALL keep resp_sum, resp_cout and resp_ovf holding their last values in IDLE and RUN; they are qualified only by resp_valid.

Reset
REQ-029 SHALL, while rst_n=0, immediately force the state to IDLE, req_ready=1, resp_valid=0, the chunk index to 0, the carry register to 0, and resp_sum, resp_cout and resp_ovf to 0.
REQ-030 SHALL, when rst_n is asserted mid-operation in RUN or DONE, abort the operation and discard the result; no resp_valid pulse follows.
REQ-031 SHALL leave reset on the first rising clk edge after rst_n deasserts, ready to accept a request.

Verification
REQ-032 SHALL verify add: a=0x0000_0000_0000_FFFF, b=0x1, sub=0 -> after 4 cycles, sum=0x0000_0000_0001_0000, cout=0, ovf=0 (carry crosses a chunk boundary).
REQ-033 SHALL verify full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0, cout=1, ovf=0.
REQ-034 SHALL verify subtract: a=0x5, b=0x7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0; separately, a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1.
REQ-035 SHALL verify backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> outputs stable, req_ready=0 throughout; with resp_ready=1, the next cycle is IDLE and req_ready=1.
REQ-036 SHALL verify reset mid-RUN: pull rst_n low during chunk 2 -> resp_valid=0, req_ready=1 immediately; a following request for 3+4 returns 7 after exactly 4 cycles.
REQ-037 SHALL verify operand isolation: change req_a and req_b every cycle during RUN -> the result matches the operands latched at accept.
